// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the sample-to-byte splitter and the UART transmitter,
// plus the serial line and status flags the transmitter drives back.
interface uart_tx_serializer_if;
  logic [7:0] in_uart_frame;
  logic       in_ready;
  logic       out_tx;
  logic       out_busy;
  logic       out_done;

  modport master (
    output in_uart_frame,
    output in_ready,
    input  out_tx,
    input  out_busy,
    input  out_done
  );

  modport slave (
    input  in_uart_frame,
    input  in_ready,
    output out_tx,
    output out_busy,
    output out_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits, then a one-cycle guard before returning to idle.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  uart_tx_serializer_if.slave  bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GUARD
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] d);
    logic x;
    x = ^d;
    return (PARITY == 1) ? ~x : x;
  endfunction

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.in_ready) begin
          shift_d = bus.in_uart_frame;
          par_d   = parity_bit(bus.in_uart_frame);
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        // done is registered, so it is raised one cycle early to land on the last stop cycle
        if (bit_q == STOP_LAST && baud_q == BAUD_PRE) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_GUARD;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_GUARD: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_tx   = tx_q;
  assign bus.out_busy = busy_q;
  assign bus.out_done = done_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-level UART transmitter directly downstream of the sample-to-byte splitter.
- Accepts one 8-bit frame per handshake and drives `out_busy` back upstream as its `tx_busy`.
- Serialises each frame onto the TX pin as start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Line rate is derived from the system clock by an integer bit-period counter.

Parameters:
- CLKS_PER_BIT, 868: system clock cycles per bit (100 MHz / 115200); legal range >= 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- in_clk  input  1  system clock; all logic on rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_uart_frame  input  8  byte to transmit; sampled only on the accept edge.
- in_ready  input  1  frame-valid level/pulse from upstream.
- out_tx  output  1  serial TX line; idle high.
- out_busy  output  1  high while a frame is in flight; upstream must not present a new frame while it is high.
- out_done  output  1  one-cycle pulse on completion of the last stop bit.

Behaviour:
- Reset (in_rst=1 at an edge): state=IDLE, out_tx=1, out_busy=0, out_done=0, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame aborts immediately: out_tx returns high on the next edge and no out_done pulse is produced.
- States are IDLE, START, DATA, PARITY, STOP, GUARD.
- IDLE:
  - If in_ready=1 at an edge: latch in_uart_frame into the shift register, compute the parity bit, and go to START.
  - On that same edge, out_busy<=1 and out_tx<=0.
- Latency: the first start-bit cycle on out_tx is exactly one clock after the accept edge.
- Each of START, DATA (per bit), PARITY, and STOP (per stop bit) holds out_tx for exactly CLKS_PER_BIT cycles.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 and resets to 0 on each bit transition.
  - Width is clog2(CLKS_PER_BIT).
- DATA:
  - Bits go out LSB first; the shift register shifts right at each bit boundary.
  - A 3-bit counter counts 0..7; after bit 7, go to PARITY if PARITY != 0, else STOP.
- Parity bit:
  - Even parity (PARITY=2): XOR of the 8 data bits, computed at latch time.
  - Odd parity (PARITY=1): the inverse of that XOR.
- STOP:
  - out_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the last cycle, pulse out_done=1 and go to GUARD.
- GUARD (exactly 1 cycle):
  - out_tx=1, out_busy stays 1.
  - Then go to IDLE with out_busy<=0.
  - Purpose: upstream samples out_busy with a one-cycle registered lag; GUARD prevents a stale in_ready from being double-accepted.
- in_ready while out_busy=1 is ignored: no latch and no error; frame data is never overwritten mid-flight.
- in_ready held high continuously: a new frame is accepted on the first IDLE edge. Frames then go out back-to-back with a fixed inter-frame gap of 1 GUARD cycle plus 1 IDLE cycle.
- Simultaneous in_rst=1 and in_ready=1: reset wins and nothing is accepted.
- Outputs out_tx, out_busy and out_done are all registered; no combinational path from inputs.

Test Plan:
- Reset then idle (CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1): hold in_rst 3 cycles -> out_tx=1, out_busy=0, out_done=0 throughout and after release.
- Single frame 0xA5:
  - Pulse in_ready 1 cycle -> out_tx=0 for 4 cycles starting 1 clk after accept.
  - Then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - out_done pulses once at the last stop cycle; out_busy falls 2 clks after the done pulse.
- Parity:
  - PARITY=2, frame 0x07 -> parity bit 1.
  - PARITY=1, frame 0x07 -> parity bit 0.
  - Total frame length 11*4 cycles plus the guard cycle.
- Busy rejection:
  - Accept 0x3C, then drive in_ready=1 with in_uart_frame=0xFF mid-DATA for 10 cycles -> serialised bits remain 0x3C.
  - 0xFF is accepted only once the block returns to IDLE, and only if in_ready is still high there.
- Back-to-back with STOP_BITS=2:
  - Hold in_ready high with data 0x12 then 0x34 (changed on out_done) -> two complete frames.
  - Each frame has 8 stop cycles; inter-frame high gap is 8+2 cycles.
  - Exactly two out_done pulses.
- Reset mid-frame: assert in_rst during DATA bit 3 of 0x55 -> next edge out_tx=1, out_busy=0, no out_done; a fresh 0x81 afterwards transmits correctly.
